// File: rtl/seq_mult.sv
// seq_mult: sequential shift-add multiplier, signed or unsigned per operation.
// One W-bit add per clock over W clocks; start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// RUN   | one add/shift iteration per clock, W iterations in total
// FIN   | sign-correct the accumulator into p, pulse done
module seq_mult #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           is_signed,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    ma;
    logic [W-1:0]    mb;
    logic            neg;
    logic [2*W-1:0]  acc;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [W:0]      sum;
    logic            last_iter;

    assign last_iter = (cnt == CW'(W - 1));

    // Operand magnitudes; -2^(W-1) negates to 2^(W-1), which still fits W bits unsigned.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (is_signed && a[W-1]) a_mag = -a;
        if (is_signed && b[W-1]) b_mag = -b;
    end

    // Partial sum: upper half of the accumulator plus ma when the current multiplier bit is set.
    always_comb begin
        sum = {1'b0, acc[2*W-1:W]};
        if (mb[0]) sum = {1'b0, acc[2*W-1:W]} + {1'b0, ma};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_iter) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and registered outputs; start outside IDLE is simply not looked at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma   <= '0;
            mb   <= '0;
            neg  <= 1'b0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            p    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ma   <= a_mag;
                        mb   <= b_mag;
                        neg  <= is_signed & (a[W-1] ^ b[W-1]);
                        acc  <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                RUN: begin
                    // The carry out of the add lands in bit 2W-1 after the shift.
                    acc <= {sum, acc[W-1:1]};
                    mb  <= mb >> 1;
                    cnt <= cnt + 1'b1;
                end
                FIN: begin
                    p    <= neg ? -acc : acc;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: three instances (W=4, 8, 16) checked
// against an arithmetic reference product.
module tb_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0, s4 = 1'b0, busy4, done4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  p4;

    logic        start8 = 1'b0, s8 = 1'b0, busy8, done8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    logic        start16 = 1'b0, s16 = 1'b0, busy16, done16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] p16;

    int n_cmp = 0;
    int n_bad = 0;

    seq_mult #(.W(4)) u_m4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .is_signed(s4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
    );
    seq_mult #(.W(8)) u_m8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(s8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
    );
    seq_mult #(.W(16)) u_m16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(s16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] cur_p(input int w);
        case (w)
            4:       return 64'(p4);
            8:       return 64'(p8);
            default: return 64'(p16);
        endcase
    endfunction

    function automatic logic cur_busy(input int w);
        case (w)
            4:       return busy4;
            8:       return busy8;
            default: return busy16;
        endcase
    endfunction

    function automatic logic cur_done(input int w);
        case (w)
            4:       return done4;
            8:       return done8;
            default: return done16;
        endcase
    endfunction

    // Reference: interpret operands as integers, multiply, keep 2W bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] av,
                                            input logic [31:0] bv, input logic sv);
        longint full, half, va, vb, prod;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        va = longint'(av) & (full - 1);
        vb = longint'(bv) & (full - 1);
        if (sv && va >= half) va = va - full;
        if (sv && vb >= half) vb = vb - full;
        prod = va * vb;
        return 64'(prod) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic set_in(input int w, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic st);
        case (w)
            4:       begin a4 = av[3:0];   b4 = bv[3:0];   s4 = sv;  start4 = st;  end
            8:       begin a8 = av[7:0];   b8 = bv[7:0];   s8 = sv;  start8 = st;  end
            default: begin a16 = av[15:0]; b16 = bv[15:0]; s16 = sv; start16 = st; end
        endcase
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    // lat counts rising edges after the start-sampling edge (-1 on timeout).
    task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, output logic [63:0] pr, output int lat,
                         output int bcnt, output bit overlap, output bit pmoved);
        logic [63:0] p0;
        logic dn;
        p0 = cur_p(w);
        set_in(w, av, bv, sv, 1'b1);
        @(negedge clk);
        set_in(w, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        lat = 0; bcnt = 0; overlap = 0; pmoved = 0; dn = 1'b0;
        while (lat <= 60) begin
            dn = cur_done(w);
            if (cur_busy(w)) bcnt++;
            if (cur_busy(w) && dn) overlap = 1;
            if (dn) break;
            if (cur_p(w) !== p0) pmoved = 1;
            @(negedge clk);
            lat++;
        end
        if (!dn) lat = -1;
        pr = cur_p(w);
    endtask

    task automatic test_reset;
        #12;
        for (int w = 4; w <= 16; w = w * 2) begin
            n_cmp++;
            if (cur_busy(w) !== 1'b0 || cur_done(w) !== 1'b0 || cur_p(w) !== 64'd0) begin
                n_bad++;
                $display("FAIL reset_w%0d: busy=%b done=%b p=%h, required 0/0/0",
                         w, cur_busy(w), cur_done(w), cur_p(w));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        int          tw [8] = '{4, 4, 4, 4, 4, 8, 8, 16};
        logic [31:0] ta [8] = '{15, 8, 8, 8, 8, 255, 'h80, 'h8000};
        logic [31:0] tb [8] = '{15, 8, 7, 8, 7, 255, 'hFF, 'h8000};
        logic        ts [8] = '{0, 1, 1, 0, 0, 0, 1, 1};
        logic [63:0] te [8] = '{225, 64, 'hC8, 64, 56, 'hFE01, 'h0080, 'h4000_0000};
        logic [63:0] pr;
        int lat, bcnt;
        bit ov, pm;
        for (int i = 0; i < 8; i++) begin
            do_op(tw[i], ta[i], tb[i], ts[i], pr, lat, bcnt, ov, pm);
            n_cmp++;
            if (pr !== te[i]) begin
                n_bad++;
                $display("FAIL directed_p[%0d]: got %h, required %h", i, pr, te[i]);
            end
            n_cmp++;
            if (lat !== tw[i] + 1 || bcnt !== tw[i] + 1) begin
                n_bad++;
                $display("FAIL directed_timing[%0d]: latency %0d busy %0d, required %0d/%0d",
                         i, lat, bcnt, tw[i] + 1, tw[i] + 1);
            end
            n_cmp++;
            if (ov || pm) begin
                n_bad++;
                $display("FAIL directed_flags[%0d]: busy&done=%0d p_moved=%0d, required 0/0",
                         i, ov, pm);
            end
        end
    endtask

    task automatic test_busy_guard;
        logic [63:0] pr;
        int lat, bcnt, n, ndone;
        bit ov, pm;
        set_in(8, 3, 5, 1'b0, 1'b1);
        @(negedge clk);
        set_in(8, 3, 5, 1'b0, 1'b0);
        @(negedge clk);
        set_in(8, 9, 9, 1'b1, 1'b1);
        @(negedge clk);
        set_in(8, 0, 0, 1'b0, 1'b0);
        n = 2;
        while (!done8 && n <= 60) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 9 || p8 !== 16'd15) begin
            n_bad++;
            $display("FAIL busy_guard_first: latency %0d p=%0d, required 9/15", n, p8);
        end
        do_op(8, 2, 7, 1'b0, pr, lat, bcnt, ov, pm);
        n_cmp++;
        if (lat !== 9 || pr !== 64'd14) begin
            n_bad++;
            $display("FAIL busy_guard_second: latency %0d p=%0d, required 9/14", lat, pr);
        end
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        n_cmp++;
        if (ndone !== 0 || p8 !== 16'd14) begin
            n_bad++;
            $display("FAIL busy_guard_idle: extra done %0d p=%0d, required 0/14", ndone, p8);
        end
    endtask

    task automatic test_reset_midop;
        logic [63:0] pr;
        int lat, bcnt, ndone;
        bit ov, pm;
        set_in(8, 100, 100, 1'b0, 1'b1);
        @(negedge clk);
        set_in(8, 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_midop: busy=%b done=%b p=%h, required 0/0/0", busy8, done8, p8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++;
            $display("FAIL reset_no_done: %0d busy/done cycles after abort, required 0", ndone);
        end
        do_op(8, 10, 10, 1'b0, pr, lat, bcnt, ov, pm);
        n_cmp++;
        if (pr !== 64'd100 || lat !== 9) begin
            n_bad++;
            $display("FAIL reset_recover: p=%0d latency %0d, required 100/9", pr, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] pr, ex;
        int lat, bcnt;
        bit ov, pm;
        logic [31:0] av, bv;
        logic sv;
        for (int i = 0; i < 6; i++) begin
            av = $urandom; bv = $urandom; sv = 1'($urandom_range(0, 1));
            ex = ref_mul(4, av, bv, sv);
            do_op(4, av, bv, sv, pr, lat, bcnt, ov, pm);
            n_cmp++;
            if (pr !== ex || lat !== 5) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: p=%h latency %0d, required %h/5", i, pr, lat, ex);
            end
        end
    endtask

    task automatic test_random;
        int widths [3] = '{4, 8, 16};
        logic [63:0] pr, ex;
        int lat, bcnt, w;
        bit ov, pm;
        logic [31:0] av, bv;
        logic sv;
        for (int k = 0; k < 3; k++) begin
            w = widths[k];
            for (int i = 0; i < 350; i++) begin
                av = $urandom; bv = $urandom; sv = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) av = (32'd1 << (w - 1));
                if ($urandom_range(0, 7) == 0) bv = '1;
                if ($urandom_range(0, 9) == 0) bv = '0;
                ex = ref_mul(w, av, bv, sv);
                do_op(w, av, bv, sv, pr, lat, bcnt, ov, pm);
                n_cmp++;
                if (pr !== ex || lat !== w + 1 || bcnt !== w + 1 || ov || pm) begin
                    n_bad++;
                    $display("FAIL random_w%0d[%0d]: a=%h b=%h s=%b p=%h lat=%0d busy=%0d ov=%0d pm=%0d, required p=%h lat=busy=%0d",
                             w, i, av, bv, sv, pr, lat, bcnt, ov, pm, ex, w + 1);
                end
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        @(negedge clk);
        test_busy_guard();
        @(negedge clk);
        test_reset_midop();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
